// File: rtl/hazard_ctrl.sv
// Decode-stage scheduler: per-register in-flight write scoreboard, RAW/saturation stall,
// timed pipeline flush and wrong-path fetch cancel.
module hazard_ctrl #(
    parameter int CNT_W        = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    input  logic       issue_fire,
    input  logic       issue_rd_wen,
    input  logic [4:0] issue_rd,
    input  logic       wb_fire,
    input  logic       wb_rd_wen,
    input  logic [4:0] wb_rd,
    input  logic       br_taken,
    input  logic       id_allow_in,
    input  logic       flush_req,
    output logic       hazard,
    output logic       clear_pipline,
    output logic       id_inst_cancel,
    output logic [5:0] busy_cnt
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam logic [FC_W-1:0]  FC_RELOAD = FC_W'(FLUSH_CYCLES - 1);
    localparam logic [FC_W-1:0]  FC_ONE    = FC_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t           state;
    logic [FC_W-1:0]  flush_cnt;
    logic             cancel_pend;
    logic [CNT_W-1:0] cnt [32];
    logic [5:0]       busy_q;
    logic [5:0]       busy_next;

    logic        idle;
    logic        inc;
    logic        dec;
    logic [31:0] inc_hit;
    logic [31:0] dec_hit;

    assign idle = (state == IDLE);
    assign inc  = issue_fire & issue_rd_wen & (issue_rd != 5'd0) & idle;
    assign dec  = wb_fire & wb_rd_wen & (wb_rd != 5'd0) & idle;

    assign inc_hit = inc ? (32'd1 << issue_rd) : 32'd0;
    assign dec_hit = dec ? (32'd1 << wb_rd) : 32'd0;

    // Entry 0 is held at zero so x0 never stalls and needs no special casing on read.
    always_ff @(posedge clk) begin
        if (rst || (idle && flush_req)) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
        end else begin
            cnt[0] <= '0;
            for (int r = 1; r < 32; r++) begin
                if (inc_hit[r] && !dec_hit[r] && (cnt[r] != CNT_MAX))
                    cnt[r] <= cnt[r] + CNT_ONE;
                else if (dec_hit[r] && !inc_hit[r] && (cnt[r] != '0))
                    cnt[r] <= cnt[r] - CNT_ONE;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst) begin
            assert (!(dec && !inc_hit[wb_rd] && (cnt[wb_rd] == '0)))
                else $error("hazard_ctrl: writeback to r%0d with no write in flight", wb_rd);
        end
    end

    always_comb begin
        busy_next = '0;
        for (int r = 1; r < 32; r++)
            busy_next = busy_next + {5'd0, (cnt[r] != '0)};
    end

    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            flush_cnt   <= '0;
            cancel_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (flush_req) begin
                        state       <= FLUSH;
                        flush_cnt   <= FC_RELOAD;
                        cancel_pend <= 1'b0;
                    end else if (id_inst_cancel) begin
                        cancel_pend <= 1'b0;
                    end else if (br_taken && !id_allow_in) begin
                        cancel_pend <= 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_req)
                        flush_cnt <= FC_RELOAD;
                    else if (flush_cnt == '0)
                        state <= IDLE;
                    else
                        flush_cnt <= flush_cnt - FC_ONE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // No writeback bypass: a register retiring this cycle still stalls until the next one.
    assign hazard = id_valid & idle &
                    ((uses_rs1 & (cnt[rs1] != '0)) |
                     (uses_rs2 & (cnt[rs2] != '0)) |
                     (issue_rd_wen & (issue_rd != 5'd0) & (cnt[issue_rd] == CNT_MAX)));

    assign clear_pipline  = (state == FLUSH);
    assign id_inst_cancel = idle & ~flush_req & (br_taken | cancel_pend) & id_allow_in;
    assign busy_cnt       = busy_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios with literal expectations plus a
// cycle-by-cycle comparison against a behavioural scoreboard model.
module tb_hazard_ctrl;

  localparam int CNT_W        = 2;
  localparam int FLUSH_CYCLES = 2;
  localparam int CMAX         = (1 << CNT_W) - 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid, uses_rs1, uses_rs2;
  logic [4:0] rs1, rs2;
  logic       issue_fire, issue_rd_wen;
  logic [4:0] issue_rd;
  logic       wb_fire, wb_rd_wen;
  logic [4:0] wb_rd;
  logic       br_taken, id_allow_in, flush_req;
  logic       hazard, clear_pipline, id_inst_cancel;
  logic [5:0] busy_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.CNT_W(CNT_W), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .rs1(rs1), .rs2(rs2),
    .uses_rs1(uses_rs1), .uses_rs2(uses_rs2), .issue_fire(issue_fire),
    .issue_rd_wen(issue_rd_wen), .issue_rd(issue_rd), .wb_fire(wb_fire),
    .wb_rd_wen(wb_rd_wen), .wb_rd(wb_rd), .br_taken(br_taken),
    .id_allow_in(id_allow_in), .flush_req(flush_req), .hazard(hazard),
    .clear_pipline(clear_pipline), .id_inst_cancel(id_inst_cancel),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural model: outstanding-write counts, remaining flush cycles, pending cancel.
  int m_cnt[32];
  int m_flush_left;
  bit m_pend;
  int m_busy;

  function automatic bit exp_hazard();
    if (!id_valid || m_flush_left > 0) return 1'b0;
    if (uses_rs1 && rs1 != 0 && m_cnt[rs1] > 0) return 1'b1;
    if (uses_rs2 && rs2 != 0 && m_cnt[rs2] > 0) return 1'b1;
    if (issue_rd_wen && issue_rd != 0 && m_cnt[issue_rd] == CMAX) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit exp_cancel();
    return (m_flush_left == 0) && !flush_req && (br_taken || m_pend) && id_allow_in;
  endfunction

  always @(posedge clk) begin : model
    int nz;
    int v;
    int delta[32];
    bit idle_now;
    bit cancel_now;
    if (rst) begin
      for (int r = 0; r < 32; r++) m_cnt[r] = 0;
      m_flush_left = 0;
      m_pend = 1'b0;
      m_busy = 0;
    end else begin
      idle_now = (m_flush_left == 0);
      cancel_now = exp_cancel();
      nz = 0;
      for (int r = 1; r < 32; r++) if (m_cnt[r] != 0) nz++;
      m_busy = nz;
      if (idle_now && flush_req) begin
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        m_pend = 1'b0;
      end else if (idle_now) begin
        for (int r = 0; r < 32; r++) delta[r] = 0;
        if (issue_fire && issue_rd_wen && issue_rd != 0) delta[issue_rd] += 1;
        if (wb_fire && wb_rd_wen && wb_rd != 0) delta[wb_rd] -= 1;
        for (int r = 1; r < 32; r++) begin
          v = m_cnt[r] + delta[r];
          m_cnt[r] = (v < 0) ? 0 : ((v > CMAX) ? CMAX : v);
        end
        if (cancel_now) m_pend = 1'b0;
        else if (br_taken && !id_allow_in) m_pend = 1'b1;
      end
      if (flush_req) m_flush_left = FLUSH_CYCLES;
      else if (m_flush_left > 0) m_flush_left--;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("hazard", int'(hazard), int'(exp_hazard()));
      chk("clear_pipline", int'(clear_pipline), int'(m_flush_left > 0));
      chk("id_inst_cancel", int'(id_inst_cancel), int'(exp_cancel()));
      chk("busy_cnt", int'(busy_cnt), m_busy);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_valid = 0; uses_rs1 = 0; uses_rs2 = 0; rs1 = 0; rs2 = 0;
    issue_fire = 0; issue_rd_wen = 0; issue_rd = 0;
    wb_fire = 0; wb_rd_wen = 0; wb_rd = 0;
    br_taken = 0; id_allow_in = 0; flush_req = 0;
  endtask

  task automatic issue(input int rd);
    issue_fire = 1; issue_rd_wen = 1; issue_rd = 5'(rd);
  endtask

  task automatic wb(input int rd);
    wb_fire = 1; wb_rd_wen = 1; wb_rd = 5'(rd);
  endtask

  initial begin
    int r;
    clr();
    rst = 1;
    repeat (2) tick();
    rst = 0;
    id_valid = 1; uses_rs1 = 1; rs1 = 5;
    #1;
    chk("reset_hazard", int'(hazard), 0);
    chk("reset_clear", int'(clear_pipline), 0);
    chk("reset_cancel", int'(id_inst_cancel), 0);
    chk("reset_busy", int'(busy_cnt), 0);
    tick();

    // RAW stall on r5 and its release one cycle after writeback
    clr(); issue(5); tick();
    clr(); id_valid = 1; uses_rs1 = 1; rs1 = 5;
    #1 chk("raw_stall", int'(hazard), 1); chk("busy_lag", int'(busy_cnt), 0);
    tick();
    wb(5);
    #1 chk("no_wb_bypass", int'(hazard), 1); chk("busy_one", int'(busy_cnt), 1);
    tick();
    wb_fire = 0; wb_rd_wen = 0;
    #1 chk("raw_release", int'(hazard), 0); chk("busy_still_one", int'(busy_cnt), 1);
    tick();
    #1 chk("busy_back_zero", int'(busy_cnt), 0);
    tick();

    // x0 is never tracked
    clr(); issue(0); tick();
    clr(); id_valid = 1; uses_rs1 = 1; rs1 = 0; issue_rd_wen = 1; issue_rd = 0;
    #1 chk("x0_no_stall", int'(hazard), 0);
    tick();
    #1 chk("x0_busy", int'(busy_cnt), 0);

    // Saturation stall on r7
    clr(); issue(7); repeat (3) tick();
    clr(); id_valid = 1; issue_rd_wen = 1; issue_rd = 7;
    #1 chk("sat_stall", int'(hazard), 1);
    wb(7);
    #1 chk("sat_stall_wb_cycle", int'(hazard), 1);
    tick();
    wb_fire = 0; wb_rd_wen = 0;
    #1 chk("sat_release", int'(hazard), 0);
    tick();
    clr(); wb(7); repeat (2) tick();

    // Simultaneous issue and writeback to r3 leaves the count unchanged
    clr(); issue(3); tick();
    issue(3); wb(3); id_valid = 1; uses_rs2 = 1; rs2 = 3;
    #1 chk("same_cycle_stall", int'(hazard), 1);
    tick();
    clr(); id_valid = 1; uses_rs2 = 1; rs2 = 3;
    #1 chk("same_cycle_keep", int'(hazard), 1);
    tick();
    clr(); wb(3); tick();

    // Flush with r4=2, r9=1; issue during flush must be ignored
    clr(); issue(4); repeat (2) tick();
    issue(9); tick();
    clr(); id_valid = 1; uses_rs1 = 1; rs1 = 4; flush_req = 1;
    #1 chk("pre_flush_stall", int'(hazard), 1); chk("pre_flush_clear", int'(clear_pipline), 0);
    tick();
    flush_req = 0; issue(9);
    #1 chk("flush1_clear", int'(clear_pipline), 1); chk("flush1_hazard", int'(hazard), 0);
    chk("flush1_busy", int'(busy_cnt), 2);
    tick();
    issue_fire = 0; issue_rd_wen = 0;
    #1 chk("flush2_clear", int'(clear_pipline), 1); chk("flush2_hazard", int'(hazard), 0);
    tick();
    rs1 = 9;
    #1 chk("post_flush_clear", int'(clear_pipline), 0); chk("post_flush_hazard", int'(hazard), 0);
    chk("post_flush_busy", int'(busy_cnt), 0);
    tick();

    // Deferred cancel while decode is blocked
    clr(); br_taken = 1; id_allow_in = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("cancel_held_off", int'(id_inst_cancel), 0);
      tick();
    end
    br_taken = 0; id_allow_in = 1;
    #1 chk("cancel_pulse", int'(id_inst_cancel), 1);
    tick();
    #1 chk("cancel_once", int'(id_inst_cancel), 0);
    tick();

    // Flush in the same cycle as the branch drops the cancel
    clr(); br_taken = 1; id_allow_in = 0; flush_req = 1;
    #1 chk("flush_br_cancel", int'(id_inst_cancel), 0);
    tick();
    clr(); repeat (2) tick();
    id_allow_in = 1;
    #1 chk("no_cancel_after_flush", int'(id_inst_cancel), 0);
    tick();
    clr(); br_taken = 1; id_allow_in = 1; flush_req = 1;
    #1 chk("flush_beats_cancel", int'(id_inst_cancel), 0);
    tick();
    clr(); repeat (3) tick();

    // Reset mid-flush and mid-stall
    clr(); issue(12); tick();
    clr(); flush_req = 1; tick();
    clr();
    #1 chk("mid_flush_clear", int'(clear_pipline), 1);
    rst = 1; tick(); rst = 0;
    #1 chk("reset_ends_flush", int'(clear_pipline), 0);
    tick();
    issue(12); tick();
    clr(); id_valid = 1; uses_rs1 = 1; rs1 = 12;
    #1 chk("mid_stall", int'(hazard), 1);
    rst = 1; tick(); rst = 0;
    #1 chk("reset_ends_stall", int'(hazard), 0); chk("reset_busy_again", int'(busy_cnt), 0);
    tick();

    // Constrained-random traffic checked by the model
    for (int n = 0; n < 400; n++) begin
      clr();
      id_valid = 1'($urandom_range(0, 1));
      uses_rs1 = 1'($urandom_range(0, 1));
      uses_rs2 = 1'($urandom_range(0, 1));
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      issue_fire = 1'($urandom_range(0, 1));
      issue_rd_wen = 1'($urandom_range(0, 3) != 0);
      issue_rd = 5'($urandom_range(0, 7));
      r = $urandom_range(1, 7);
      if (m_cnt[r] > 0 && $urandom_range(0, 1) == 1) wb(r);
      else if ($urandom_range(0, 3) == 0) begin
        wb_fire = 1; wb_rd_wen = 0; wb_rd = 5'($urandom_range(0, 31));
      end
      br_taken = 1'($urandom_range(0, 3) == 0);
      id_allow_in = 1'($urandom_range(0, 1));
      flush_req = 1'($urandom_range(0, 24) == 0);
      tick();
    end

    clr();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
